// File: rtl/sphere_point_buffer.sv
// Request/capture stage for the sphere point generator: one outstanding pop,
// first-word-fall-through FIFO of (x, y, z) triples on a valid/ready output.
module sphere_point_buffer #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic                       flush,
  output logic                       gen_pop,
  input  logic [DATA_W-1:0]          gen_x,
  input  logic [DATA_W-1:0]          gen_y,
  input  logic [DATA_W-1:0]          gen_z,
  input  logic                       gen_valid,
  output logic [DATA_W-1:0]          out_x,
  output logic [DATA_W-1:0]          out_y,
  output logic [DATA_W-1:0]          out_z,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       timeout_err,
  output logic                       stray_err
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned TMO_W = $clog2(TIMEOUT);
  localparam int unsigned ENT_W = 3 * DATA_W;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DISCARD
  } state_t;

  state_t             state;
  logic [TMO_W-1:0]   tmo;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [ENT_W-1:0]   mem [DEPTH];
  logic               wr_en;
  logic               rd_en;
  logic               tmo_hit;
  logic               has_room;

  always_comb begin
    out_valid = (count != '0);
    rd_en     = out_valid && out_ready && !flush;
    wr_en     = (state == WAIT) && gen_valid && !flush;
    tmo_hit   = (tmo == TMO_W'(TIMEOUT - 1));
    has_room  = (count < CNT_W'(DEPTH));
    {out_x, out_y, out_z} = mem[rd_ptr];
  end

  // Request FSM; a slot is reserved by only requesting while count < DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      gen_pop     <= 1'b0;
      tmo         <= '0;
      timeout_err <= 1'b0;
      stray_err   <= 1'b0;
    end else if (flush) begin
      state       <= (state == WAIT) ? DISCARD : IDLE;
      gen_pop     <= 1'b0;
      timeout_err <= 1'b0;
      stray_err   <= 1'b0;
    end else begin
      gen_pop <= 1'b0;
      case (state)
        IDLE: begin
          if (gen_valid) stray_err <= 1'b1;
          if (enable && has_room) begin
            state   <= WAIT;
            gen_pop <= 1'b1;
            tmo     <= '0;
          end
        end
        WAIT: begin
          if (gen_valid) begin
            state <= IDLE;
          end else if (tmo_hit) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        DISCARD: begin
          if (gen_valid || tmo_hit) state <= IDLE;
          else                      tmo   <= tmo + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= {gen_x, gen_y, gen_z};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
